// File: rtl/regbank_reader_if.sv
// Word-stream channel of regbank_reader: data, index and last flag under a valid/ready handshake.
interface regbank_reader_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 10
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regbank_reader.sv
// regbank_reader: snapshots a flat register bank on start and streams it out one word per handshake.
// Optional abort input is built in when REGBANK_READER_ABORT_EN is defined.
module regbank_reader #(
    parameter int WIDTH = 8,
    parameter int NREGS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*NREGS-1:0] bank_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
`ifdef REGBANK_READER_ABORT_EN
    input  logic                   abort,
`endif
    regbank_reader_if.master       rd
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

    logic [0:0]             state;
    logic [IDXW-1:0]        index;
    logic [WIDTH*NREGS-1:0] snapshot;
    logic [WIDTH-1:0]       word;
    logic                   is_last;
    logic                   abort_req;

`ifdef REGBANK_READER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign is_last = (index == LAST_IDX);

    // Word select from the registered snapshot only, so outputs never see bank_in directly
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (index == IDXW'(i)) begin
                word = snapshot[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            snapshot <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    snapshot <= bank_in;
                    index    <= '0;
                    state    <= SEND;
                end
            end else begin
                // Abort wins over any handshake in the same cycle
                if (abort_req) begin
                    index <= '0;
                    state <= IDLE;
                end else if (rd.out_ready) begin
                    if (is_last) begin
                        index <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        index <= index + IDXW'(1);
                    end
                end
            end
        end
    end

    assign busy         = (state == SEND);
    assign rd.out_valid = (state == SEND);
    assign rd.out_data  = word;
    assign rd.out_idx   = index;
    assign rd.out_last  = (state == SEND) && is_last;
endmodule

// File: tb/tb_regbank_reader.sv
// Scoreboard bench for regbank_reader: a 4-word and a 1-word instance share stimulus, each with its own model.
`timescale 1ns/1ps
module tb_regbank_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        abort;
    logic [31:0] bank;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regbank_reader_if #(.WIDTH(8), .NREGS(4)) rd0 ();
    regbank_reader_if #(.WIDTH(8), .NREGS(1)) rd1 ();

    logic busy0, done0, busy1, done1;

    assign rd0.out_ready = ready;
    assign rd1.out_ready = ready;

    regbank_reader #(.WIDTH(8), .NREGS(4)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bank_in (bank),
        .start   (start),
        .busy    (busy0),
        .done    (done0),
`ifdef REGBANK_READER_ABORT_EN
        .abort   (abort),
`endif
        .rd      (rd0)
    );

    regbank_reader #(.WIDTH(8), .NREGS(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bank_in (bank[7:0]),
        .start   (start),
        .busy    (busy1),
        .done    (done1),
`ifdef REGBANK_READER_ABORT_EN
        .abort   (abort),
`endif
        .rd      (rd1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] i;
        logic       l;
    } exp_t;

    exp_t        q [2][$];
    logic        mbusy [2] = '{1'b0, 1'b0};
    logic        mdone [2] = '{1'b0, 1'b0};
    int unsigned nw    [2] = '{4, 1};
    logic [7:0]  od [2];
    logic [7:0]  oi [2];
    logic        ov [2];
    logic        ol [2];
    logic        ob [2];
    logic        odn [2];
    logic        ab;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 0, 32'(rd0.out_valid), 32'h0);
        check("rst_busy",  0, 32'(busy0),         32'h0);
        check("rst_done",  0, 32'(done0),         32'h0);
        check("rst_idx",   0, 32'(rd0.out_idx),   32'h0);
        check("rst_data",  0, 32'(rd0.out_data),  32'h0);
        check("rst_last",  0, 32'(rd0.out_last),  32'h0);
        check("rst_valid", 1, 32'(rd1.out_valid), 32'h0);
        check("rst_busy",  1, 32'(busy1),         32'h0);
        check("rst_done",  1, 32'(done1),         32'h0);
        check("rst_data",  1, 32'(rd1.out_data),  32'h0);
        check("rst_last",  1, 32'(rd1.out_last),  32'h0);
    endtask

    // Model: a started read-out is simply the list of bank words; it drains one per accepted cycle
    always @(negedge clk) begin
        od[0] = rd0.out_data; oi[0] = 8'(rd0.out_idx); ov[0] = rd0.out_valid;
        ol[0] = rd0.out_last; ob[0] = busy0;           odn[0] = done0;
        od[1] = rd1.out_data; oi[1] = 8'(rd1.out_idx); ov[1] = rd1.out_valid;
        ol[1] = rd1.out_last; ob[1] = busy1;           odn[1] = done1;
        ab = 1'b0;
`ifdef REGBANK_READER_ABORT_EN
        ab = abort;
`endif
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                q[k].delete();
                mbusy[k] = 1'b0;
                mdone[k] = 1'b0;
            end else begin
                check("busy",  k, 32'(ob[k]),  32'(mbusy[k]));
                check("valid", k, 32'(ov[k]),  32'(mbusy[k]));
                check("done",  k, 32'(odn[k]), 32'(mdone[k]));
                if (mbusy[k] && q[k].size() > 0) begin
                    check("data", k, 32'(od[k]), 32'(q[k][0].d));
                    check("idx",  k, 32'(oi[k]), 32'(q[k][0].i));
                    check("last", k, 32'(ol[k]), 32'(q[k][0].l));
                end
                mdone[k] = 1'b0;
                if (mbusy[k]) begin
                    if (ab) begin
                        q[k].delete();
                        mbusy[k] = 1'b0;
                    end else if (ready) begin
                        void'(q[k].pop_front());
                        if (q[k].size() == 0) begin
                            mbusy[k] = 1'b0;
                            mdone[k] = 1'b1;
                        end
                    end
                end else if (start) begin
                    for (int unsigned i = 0; i < nw[k]; i++) begin
                        q[k].push_back('{d: bank[i*8 +: 8], i: 8'(i), l: (i == nw[k] - 1)});
                    end
                    mbusy[k] = 1'b1;
                end
            end
        end
    end

    task automatic drive(input logic s, input logic r, input logic [31:0] b, input logic a);
        @(posedge clk);
        #1;
        start = s;
        ready = r;
        bank  = b;
        abort = a;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; abort = 1'b0; bank = '0;
        #2 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 32'hDDCCBBAA, 1'b0);

        // Streaming with ready held high
        drive(1'b1, 1'b1, 32'hDDCCBBAA, 1'b0);
        repeat (6) drive(1'b0, 1'b1, 32'hDDCCBBAA, 1'b0);

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        drive(1'b1, 1'b1, 32'hDDCCBBAA, 1'b0);
        for (int c = 0; c < 16; c++) drive(1'b0, (c % 3) == 0, 32'hDDCCBBAA, 1'b0);

        // Snapshot isolation, start held high during SEND
        drive(1'b1, 1'b1, 32'h04030201, 1'b0);
        repeat (4) drive(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);

        // Back-to-back: start asserted through the done cycle
        drive(1'b1, 1'b1, 32'hDDCCBBAA, 1'b0);
        repeat (5) drive(1'b1, 1'b1, 32'h44332211, 1'b0);
        repeat (6) drive(1'b0, 1'b1, 32'h44332211, 1'b0);

`ifdef REGBANK_READER_ABORT_EN
        // Abort while idx 2 is presented, then a fresh read-out
        drive(1'b1, 1'b1, 32'hDDCCBBAA, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 32'hDDCCBBAA, 1'b0);
        drive(1'b0, 1'b0, 32'hDDCCBBAA, 1'b1);
        repeat (2) drive(1'b0, 1'b1, 32'h44332211, 1'b0);
        drive(1'b1, 1'b1, 32'h44332211, 1'b0);
        repeat (6) drive(1'b0, 1'b1, 32'h44332211, 1'b0);
`endif

        // Asynchronous reset in the middle of a read-out
        drive(1'b1, 1'b0, 32'h55667788, 1'b0);
        drive(1'b0, 1'b1, 32'h55667788, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) drive(1'b0, 1'b1, 32'h0, 1'b0);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 32'h12345678, 1'b0);

        // Randomized traffic
        repeat (400) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 19) == 0);
        end

        repeat (8) drive(1'b0, 1'b1, 32'h0, 1'b0);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regbank_reader.md
# regbank_reader

Read-out engine for a register bank. On a start request it snapshots the flat WIDTH*NREGS bank contents. It then streams the words out one per handshake, index 0 first, over a valid/ready interface. It sits between a parallel register bank and a narrow consumer such as a debug port, bus bridge or serial link, so the consumer can drain the whole bank without a wide datapath.

## Interface
- WIDTH, 8, bits per register word (>=1)
- NREGS, 10, number of words in the bank (>=1)
- IDXW, derived = max(1, $clog2(NREGS)), width of word index (localparam)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- bank_in  in  WIDTH*NREGS  flat bank contents; word i = bank_in[i*WIDTH +: WIDTH]
- start  in  1  read-out request, sampled only in IDLE
- busy  out  1  high while a read-out is in progress (state SEND)
- out_data  out  WIDTH  current word, from snapshot
- out_idx  out  IDXW  index of current word
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_last  out  1  current word is index NREGS-1 (qualified by out_valid)
- done  out  1  one-cycle pulse after final word accepted
- abort  in  1  only present with REGBANK_READER_ABORT_EN

## Operation
- Internal state:
  - snapshot register, WIDTH*NREGS bits
  - index counter, IDXW bits
  - FSM with states IDLE and SEND
  - done flag
- Reset (async, rst_n=0):
  - state IDLE, index 0, snapshot all zeros
  - busy=0, out_valid=0, out_last=0, done=0, out_idx=0, out_data=0
- IDLE:
  - start=1 → snapshot <= bank_in, index <= 0, next state SEND.
  - start=0 → stay in IDLE.
  - out_valid=0 in IDLE.
- SEND:
  - out_valid=1, busy=1.
  - out_data = snapshot word[index]; out_idx = index; out_last = (index == NREGS-1).
  - On handshake (out_valid & out_ready) with index < NREGS-1: index <= index+1, stay in SEND.
  - On handshake with index == NREGS-1: index <= 0, done <= 1 for the next cycle, next state IDLE.
  - No handshake: all outputs held stable (valid must not drop and data must not change until accepted).
- Changes on bank_in after the snapshot have no effect on the words in flight.
- start while in SEND is ignored; it is not queued.
- done is registered and high exactly one cycle, coinciding with the first IDLE cycle. A start in that cycle is accepted.
- NREGS=1: the single word carries out_last=1 immediately.
- Index never exceeds NREGS-1; no wrap beyond the bank.

## Timing
- Start sampled at edge E → out_valid=1 with word 0 from the cycle after E.
- With out_ready held high: word i is accepted i+1 cycles after E. Final handshake is at edge E+NREGS; done and busy=0 hold in the cycle after that edge.
- Minimum start-to-start period is NREGS+1 cycles.
- out_data, out_idx, out_last and out_valid depend only on registered state. There is no combinational path from bank_in, start or out_ready to any output.
- Latency per word is 0 cycles from ready: acceptance takes effect at the same edge.

## Configuration
- Macro: REGBANK_READER_ABORT_EN.
- Defined:
  - abort port exists.
  - abort=1 in SEND → next state IDLE, index <= 0, no done pulse. A handshake in the same cycle is still counted as accepted by the consumer, but no further words are issued.
  - abort=1 in IDLE has no effect; start is still honoured in that cycle.
  - abort has priority over handshake progression.
- Undefined: no abort port; a read-out always runs to completion.

## Test plan
All scenarios use WIDTH=8, NREGS=4 unless stated.
- Reset: rst_n=0 asserted asynchronously mid-SEND → all outputs 0 immediately, state IDLE. After release, out_valid stays 0 until start.
- Streaming: bank_in=32'hDDCCBBAA, start pulse, out_ready=1 → words AA,BB,CC,DD with idx 0..3 on 4 consecutive cycles, out_last only on DD. done=1 the next cycle, busy=0.
- Backpressure: same bank, out_ready toggling 1,0,0,1,... → each word held stable while ready=0, order AA,BB,CC,DD, no duplicate or skipped index.
- Snapshot isolation: start with bank_in=32'h04030201, change bank_in to 32'hFFFFFFFF the next cycle → output still 01,02,03,04. start pulses during SEND are ignored.
- Back-to-back: start asserted in the done cycle with bank_in=32'h44332211 → second stream 11,22,33,44 begins the following cycle. NREGS=1 variant: single word with out_last=1, then done.
- Abort (REGBANK_READER_ABORT_EN): abort=1 while idx=2 is presented → IDLE next cycle, no done pulse, next start streams from idx 0.
